subtraction_fp_seq: RTL and testbench

Sequential IEEE-754 single-precision subtractor computing o = a − b with a valid/busy handshake. It is the inverse-operation companion of the team's combinational FP adder and is used in the Q-learning datapath for TD-error and Q-update differences. The block runs a multi-cycle align / operate / normalise FSM instead of one long combinational path. Its numeric conventions match the adder: truncation, no rounding, and no denormals.

---
 rtl/subtraction_fp_seq.sv | 258 +++++++++++++++++++++++++
 tb/tb_subtraction_fp_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/subtraction_fp_seq.sv
// subtraction_fp_seq: sequential IEEE-754 single-precision subtractor, o = a - b.
// Multi-cycle IDLE -> ALIGN -> OP -> NORM datapath with a valid/busy handshake.
// Numeric behaviour: truncation (no rounding), zero-exponent operands read as
// zero, results that would be denormal are flushed to +0.
// Build macro SUB_FP_FAST_NORM_EN: when defined, NORM finishes in one cycle
// using a leading-zero count and barrel shift; results are bit-identical.
module subtraction_fp_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        valid_in,
  output logic        busy,
  output logic [31:0] o,
  output logic        valid_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_OP    = 2'd2,
    ST_NORM  = 2'd3
  } state_t;

  state_t      state_q;
  logic        sa_q;        // sign of a
  logic        sb_q;        // sign of -b
  logic        a_big_q;     // a has the larger (or equal) exponent
  logic [7:0]  ediff_q;
  logic [23:0] ma_q;
  logic [23:0] mb_q;
  logic [23:0] tm_q;
  logic [7:0]  te_q;
  logic        ts_q;
  logic [31:0] o_q;
  logic        valid_q;
  logic        busy_q;

  assign busy      = busy_q;
  assign o         = o_q;
  assign valid_out = valid_q;

  // ---------------------------------------------------------------- decode
  logic [7:0]  ea_s;
  logic [7:0]  eb_s;
  logic [7:0]  emax_s;
  logic [7:0]  ediff_s;
  logic [23:0] ma_s;
  logic [23:0] mb_s;
  logic        a_ge_s;

  // Unpack operands and work out the larger exponent and the alignment distance.
  always_comb begin
    ea_s = a[30:23];
    eb_s = b[30:23];
    if (ea_s == 8'd0) begin
      ma_s = 24'd0;
    end else begin
      ma_s = {1'b1, a[22:0]};
    end
    if (eb_s == 8'd0) begin
      mb_s = 24'd0;
    end else begin
      mb_s = {1'b1, b[22:0]};
    end
    a_ge_s = (ea_s >= eb_s);
    if (a_ge_s) begin
      emax_s  = ea_s;
      ediff_s = ea_s - eb_s;
    end else begin
      emax_s  = eb_s;
      ediff_s = eb_s - ea_s;
    end
  end

  // ---------------------------------------------------------------- align
  logic [23:0] small_s;
  logic [23:0] small_sh_s;

  // Right-shift the smaller-exponent mantissa; 24 or more positions leaves nothing.
  always_comb begin
    if (a_big_q) begin
      small_s = mb_q;
    end else begin
      small_s = ma_q;
    end
    if (ediff_q >= 8'd24) begin
      small_sh_s = 24'd0;
    end else begin
      small_sh_s = small_s >> ediff_q;
    end
  end

  // ---------------------------------------------------------------- operate
  logic [24:0] sum_s;
  logic [23:0] op_tm_s;
  logic [7:0]  op_te_s;
  logic        op_ts_s;

  // Effective add or magnitude subtract of the aligned mantissas.
  always_comb begin
    sum_s   = {1'b0, ma_q} + {1'b0, mb_q};
    op_te_s = te_q;
    op_tm_s = 24'd0;
    op_ts_s = 1'b0;
    if (sa_q == sb_q) begin
      op_ts_s = sa_q;
      if (sum_s[24]) begin
        op_te_s = te_q + 8'd1;
        // Carry out of the top binade saturates to infinity (frac forced to 0).
        if (te_q == 8'd254) begin
          op_tm_s = 24'h800000;
        end else begin
          op_tm_s = sum_s[24:1];
        end
      end else begin
        op_tm_s = sum_s[23:0];
      end
    end else if (ma_q > mb_q) begin
      op_tm_s = ma_q - mb_q;
      op_ts_s = sa_q;
    end else if (mb_q > ma_q) begin
      op_tm_s = mb_q - ma_q;
      op_ts_s = sb_q;
    end else begin
      // Exact cancellation always yields +0.
      op_tm_s = 24'd0;
      op_ts_s = 1'b0;
    end
  end

  // ---------------------------------------------------------------- normalise
  logic        norm_done_s;
  logic [31:0] norm_res_s;
  logic [23:0] norm_tm_s;
  logic [7:0]  norm_te_s;

`ifdef SUB_FP_FAST_NORM_EN
  function automatic logic [4:0] lzc24(input logic [23:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd24;
    found = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 5'(23 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  logic [4:0]  lzc_s;
  logic [23:0] shifted_s;

  // One-shot normalisation; an exponent that would drop below 1 flushes to +0.
  always_comb begin
    lzc_s       = lzc24(tm_q);
    shifted_s   = tm_q << lzc_s;
    norm_done_s = 1'b1;
    norm_tm_s   = shifted_s;
    norm_te_s   = te_q;
    if (tm_q == 24'd0) begin
      norm_res_s = 32'd0;
    end else if ({3'd0, lzc_s} >= te_q) begin
      norm_res_s = 32'd0;
    end else begin
      norm_res_s = {ts_q, te_q - {3'd0, lzc_s}, shifted_s[22:0]};
    end
  end
`else
  // One normalisation step per cycle; result forms when the hidden bit is set.
  always_comb begin
    norm_tm_s   = {tm_q[22:0], 1'b0};
    norm_te_s   = te_q - 8'd1;
    norm_done_s = 1'b1;
    norm_res_s  = 32'd0;
    if (tm_q == 24'd0) begin
      norm_res_s = 32'd0;
    end else if (tm_q[23]) begin
      norm_res_s = {ts_q, te_q, tm_q[22:0]};
    end else if (te_q == 8'd1) begin
      norm_res_s = 32'd0;
    end else begin
      norm_done_s = 1'b0;
    end
  end
`endif

  // ---------------------------------------------------------------- control
  // Sequencer and all datapath/output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      a_big_q <= 1'b0;
      ediff_q <= 8'd0;
      ma_q    <= 24'd0;
      mb_q    <= 24'd0;
      tm_q    <= 24'd0;
      te_q    <= 8'd0;
      ts_q    <= 1'b0;
      o_q     <= 32'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (valid_in) begin
            sa_q    <= a[31];
            sb_q    <= ~b[31];
            a_big_q <= a_ge_s;
            ediff_q <= ediff_s;
            ma_q    <= ma_s;
            mb_q    <= mb_s;
            te_q    <= emax_s;
            busy_q  <= 1'b1;
            state_q <= ST_ALIGN;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ALIGN: begin
          if (a_big_q) begin
            mb_q <= small_sh_s;
          end else begin
            ma_q <= small_sh_s;
          end
          state_q <= ST_OP;
        end
        ST_OP: begin
          tm_q    <= op_tm_s;
          te_q    <= op_te_s;
          ts_q    <= op_ts_s;
          state_q <= ST_NORM;
        end
        ST_NORM: begin
          if (norm_done_s) begin
            o_q     <= norm_res_s;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            tm_q <= norm_tm_s;
            te_q <= norm_te_s;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_subtraction_fp_seq.sv
// Self-checking bench for subtraction_fp_seq: a reference model predicts each
// accepted operation (result and latency) into a scoreboard queue; a monitor
// pops and compares on every valid_out and tracks busy cycle by cycle.
module tb_subtraction_fp_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic        valid_in;
  logic        busy;
  logic [31:0] o;
  logic        valid_out;

  subtraction_fp_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .valid_in  (valid_in),
    .busy      (busy),
    .o         (o),
    .valid_out (valid_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          edge0;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur_e;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          edge_n   = 0;
  int          m_cnt    = 0;
  bit          mon_en   = 1'b0;
  bit          dir_v    = 1'b0;
  logic [31:0] dir_res  = 32'd0;
  int          dir_k    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, want, $time);
    end
  endtask

  // Reference: decode, align with truncation, add/sub, normalise or flush.
  function automatic logic [31:0] ref_sub(input logic [31:0] x, input logic [31:0] y, output int k);
    int     ex, ey, te, d;
    longint mx, my, tm;
    bit     sx, sy, ts;
    k  = 0;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    mx = (ex == 0) ? 64'd0 : longint'({1'b1, x[22:0]});
    my = (ey == 0) ? 64'd0 : longint'({1'b1, y[22:0]});
    sx = x[31];
    sy = ~y[31];
    if (ex >= ey) begin
      te = ex; d = ex - ey;
      my = (d >= 24) ? 64'd0 : (my >> d);
    end else begin
      te = ey; d = ey - ex;
      mx = (d >= 24) ? 64'd0 : (mx >> d);
    end
    if (sx == sy) begin
      tm = mx + my; ts = sx;
      if (tm >= 64'h1000000) begin
        tm = tm / 2; te = te + 1;
        if (te == 255) tm = 64'h800000;
      end
    end else if (mx > my) begin
      tm = mx - my; ts = sx;
    end else begin
      tm = my - mx; ts = sy;
      if (tm == 0) ts = 1'b0;
    end
    if (tm == 0) return 32'd0;
    while (tm < 64'h800000 && te > 1) begin
      tm = tm * 2; te = te - 1; k = k + 1;
    end
    if (tm < 64'h800000) return 32'd0;
    return {ts, 8'(te), 23'(tm)};
  endfunction

  function automatic exp_t mk_exp(input logic [31:0] xa, input logic [31:0] xb, input bit dv,
                                  input logic [31:0] dres, input int dk, input int e0);
    exp_t e;
    int   k;
    if (dv) begin
      e.res = dres; k = dk;
    end else begin
      e.res = ref_sub(xa, xb, k);
    end
`ifdef SUB_FP_FAST_NORM_EN
    e.lat = 3;
`else
    e.lat = 3 + k;
`endif
    e.edge0 = e0;
    return e;
  endfunction

  // Handshake model: predicts accepts and busy, pushes expected results.
  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    if (!rst_n) begin
      m_cnt <= 0;
      exp_q.delete();
    end else if (m_cnt == 0) begin
      if (valid_in) begin
        exp_q.push_back(mk_exp(a, b, dir_v, dir_res, dir_k, edge_n + 1));
        m_cnt <= exp_q[$].lat;
      end
    end else begin
      m_cnt <= m_cnt - 1;
    end
  end

  // Monitor: busy every cycle, result and latency on each valid_out.
  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("busy", 32'(busy), 32'(m_cnt != 0));
      if (valid_out === 1'b1) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_valid_out", 32'(valid_out), 32'd0);
        end else begin
          cur_e = exp_q.pop_front();
          check_eq("o", o, cur_e.res);
          check_eq("latency", 32'(edge_n - cur_e.edge0), 32'(cur_e.lat));
        end
      end
    end
  end

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check_eq("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb2, input bit dv,
                        input logic [31:0] dres, input int dk);
    @(negedge clk);
    a = ta; b = tb2; dir_v = dv; dir_res = dres; dir_k = dk; valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0; dir_v = 1'b0;
    drain();
  endtask

  function automatic logic [31:0] rnd_fp();
    logic [31:0] v;
    v = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 140)), 23'($urandom)};
    if ($urandom_range(0, 7) == 0) v = 32'd0;
    return v;
  endfunction

  function automatic logic [31:0] rnd_b(input logic [31:0] xa);
    logic [31:0] v;
    if ($urandom_range(0, 2) == 0) v = xa ^ 32'($urandom_range(1, 4095));
    else v = rnd_fp();
    return v;
  endfunction

  typedef struct {
    logic [31:0] xa;
    logic [31:0] xb;
    logic [31:0] res;
    int          k;
  } dir_t;

  dir_t dirs[10] = '{
    '{32'h40400000, 32'h3F800000, 32'h40000000, 0},
    '{32'h3F800000, 32'h3F400000, 32'h3E800000, 2},
    '{32'h3F800000, 32'hBF800000, 32'h40000000, 0},
    '{32'h40000000, 32'h40400000, 32'hBF800000, 1},
    '{32'h3F800000, 32'h3F800000, 32'h00000000, 0},
    '{32'h3F800000, 32'h30800000, 32'h3F800000, 0},
    '{32'h00000000, 32'h3F800000, 32'hBF800000, 0},
    '{32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 0},
    '{32'h00C00000, 32'h00800000, 32'h00000000, 0},
    '{32'h01400000, 32'h01000000, 32'h00800000, 1}
  };

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; a = 32'd0; b = 32'd0;
    repeat (2) @(negedge clk);
    check_eq("reset_o", o, 32'd0);
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_valid_out", 32'(valid_out), 32'd0);
    mon_en = 1'b1;
    rst_n  = 1'b1;

    // Directed values with known results and normalisation counts.
    foreach (dirs[i]) run_op(dirs[i].xa, dirs[i].xb, 1'b1, dirs[i].res, dirs[i].k);

    // Isolated random operations, including deep cancellations.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra;
      ra = rnd_fp();
      run_op(ra, rnd_b(ra), 1'b0, 32'd0, 0);
    end

    // valid_in held high with new operands every cycle: drops while busy,
    // back-to-back accepts right after each valid_out.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      a = rnd_fp(); b = rnd_b(a); valid_in = 1'b1;
    end
    @(negedge clk);
    valid_in = 1'b0;
    drain();

    // Reset mid-NORM of 1.0 - 0.75, then a normal operation.
    @(negedge clk);
    a = 32'h3F800000; b = 32'h3F400000; dir_v = 1'b1; dir_res = 32'h3E800000; dir_k = 2;
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0; dir_v = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("rst_mid_o", o, 32'd0);
    check_eq("rst_mid_busy", 32'(busy), 32'd0);
    check_eq("rst_mid_valid_out", 32'(valid_out), 32'd0);
    repeat (4) @(negedge clk);
    run_op(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 0);

    repeat (3) @(negedge clk);
    check_eq("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
